fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage pipelined MIPS core. Holds the program counter, selects the next PC from sequential/branch/jump/register redirects resolved in decode, drives the fetch address to the instruction memory, and latches the returned instruction into the IF/ID pipeline register. Sits between the hazard/decode logic (redirect and stall sources) and the decode stage (consumer of the IF/ID register).

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on a flush.

- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- npc_sel  in  2  decode redirect: 00 sequential, 01 branch, 10 jump (j/jal), 11 register (jr/jalr).
- imm16  in  16  branch offset from the instruction in IF/ID.
- instr_index  in  26  jump field from the instruction in IF/ID.
- jr_target  in  32  forwarded register value for jr/jalr.
- ir_f  in  32  instruction word from instruction memory (combinational read of pc_f).
- pc_f  out  32  fetch address to instruction memory.
- ir_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC of ir_d.
- pc8_d  out  32  IF/ID link value (pc_d + 8).
- valid_d  out  1  IF/ID holds a real fetched instruction (0 = bubble).

## Operation
- Registers: pc_f, ir_d, pc_d, pc8_d, valid_d. All outputs are register outputs.
- Reset values: pc_f = RESET_PC; ir_d = NOP_WORD; pc_d = 0; pc8_d = 0; valid_d = 0.
- Next-PC (all arithmetic 32-bit, modulo 2^32, wrap silently):
  - 00: pc_f + 4.
  - 01: pc_d + 4 + (sign_ext(imm16) << 2).
  - 10: {pc_d_plus4[31:28], instr_index, 2'b00}, where pc_d_plus4 = pc_d + 4.
  - 11: jr_target, used unmodified (no alignment check).
- Redirect targets are relative to pc_d (the branch in decode), never pc_f.
- Priority per edge: reset > stall > redirect > sequential.
- stall = 1: pc_f, ir_d, pc_d, pc8_d, valid_d all hold; npc_sel ignored (decode holds the branch, so the redirect re-presents next cycle).
- stall = 0: pc_f <= next-PC; IF/ID <= {ir_f, pc_f, pc_f + 8, 1} unless flushed (see Configuration).
- npc_sel is only honoured while valid_d = 1; with valid_d = 0 it is treated as 00.

## Timing
- Fetch: pc_f issued in cycle N, ir_f returned combinationally in N, captured in IF/ID at end of N; visible on ir_d in N+1.
- Redirect: npc_sel asserted in cycle N (branch on ir_d) -> pc_f = target in N+1; first target instruction on ir_d in N+2.
- Reset mid-operation: next edge forces all reset values regardless of stall/npc_sel; first valid instruction (at RESET_PC) appears on ir_d one cycle after reset deasserts.
- Stall and redirect in same cycle: stall wins, no state change.
- Stall held K cycles: outputs constant for K cycles, resume on first cycle stall = 0.

## Configuration
- FETCH_DELAY_SLOT_EN defined: MIPS branch delay slot. The instruction fetched in the redirect cycle (at pc_d + 4) enters IF/ID normally with valid_d = 1; no flush.
- FETCH_DELAY_SLOT_EN undefined: on a non-stalled redirect (npc_sel != 00, valid_d = 1), IF/ID loads ir_d = NOP_WORD, pc_d = 0, pc8_d = 0, valid_d = 0; pc_f still loads the target.

## Test plan
- Reset then 4 free cycles, memory returns pc-tagged words -> pc_f = 0x3000, 0x3004, 0x3008, 0x300C; ir_d lags by one cycle; pc8_d = pc_d + 8.
- Branch at pc_d = 0x3008, npc_sel = 01, imm16 = 0xFFFE -> next pc_f = 0x3004; with macro ir_d = word@0x300C valid, without macro ir_d = 0, valid_d = 0.
- Jump at pc_d = 0x3010, npc_sel = 10, instr_index = 0x0000C40 -> pc_f = 0x0000_3100.
- jr with jr_target = 0x0000_3FFC and stall = 1 same cycle -> no change; stall drops next cycle -> pc_f = 0x3FFC.
- pc_f = 0xFFFF_FFFC sequential -> pc_f = 0x0000_0000 (wrap); reset asserted while stall = 1 -> pc_f = 0x3000, valid_d = 0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional macro FETCH_DELAY_SLOT_EN keeps the delay-slot instruction instead of flushing it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  input  logic [31:0] ir_f,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ir_d_q, ir_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pc8_d_q, pc8_d_d;
  logic        valid_d_q, valid_d_d;

  logic [1:0]  sel_s;
  logic [31:0] pc_d_plus4_s;
  logic [31:0] br_off_s;
  logic [31:0] npc_s;

  // Next-PC select; a bubble in decode cannot redirect, so its npc_sel is masked.
  always_comb begin
    sel_s        = valid_d_q ? npc_sel : 2'b00;
    pc_d_plus4_s = pc_d_q + 32'd4;
    br_off_s     = {{14{imm16[15]}}, imm16, 2'b00};
    case (sel_s)
      2'b00:   npc_s = pc_f_q + 32'd4;
      2'b01:   npc_s = pc_d_plus4_s + br_off_s;
      2'b10:   npc_s = {pc_d_plus4_s[31:28], instr_index, 2'b00};
      2'b11:   npc_s = jr_target;
      default: npc_s = pc_f_q + 32'd4;
    endcase
  end

  always_comb begin
    pc_f_d    = pc_f_q;
    ir_d_d    = ir_d_q;
    pc_d_d    = pc_d_q;
    pc8_d_d   = pc8_d_q;
    valid_d_d = valid_d_q;
    if (stall) begin
      pc_f_d    = pc_f_q;
      valid_d_d = valid_d_q;
    end else begin
      pc_f_d    = npc_s;
      ir_d_d    = ir_f;
      pc_d_d    = pc_f_q;
      pc8_d_d   = pc_f_q + 32'd8;
      valid_d_d = 1'b1;
`ifndef FETCH_DELAY_SLOT_EN
      // Without delay slots the wrong-path fetch of the redirect cycle becomes a bubble.
      if (sel_s != 2'b00) begin
        ir_d_d    = NOP_WORD;
        pc_d_d    = 32'h0000_0000;
        pc8_d_d   = 32'h0000_0000;
        valid_d_d = 1'b0;
      end else begin
        valid_d_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= RESET_PC;
      ir_d_q    <= NOP_WORD;
      pc_d_q    <= 32'h0000_0000;
      pc8_d_q   <= 32'h0000_0000;
      valid_d_q <= 1'b0;
    end else begin
      pc_f_q    <= pc_f_d;
      ir_d_q    <= ir_d_d;
      pc_d_q    <= pc_d_d;
      pc8_d_q   <= pc8_d_d;
      valid_d_q <= valid_d_d;
    end
  end

  assign pc_f    = pc_f_q;
  assign ir_d    = ir_d_q;
  assign pc_d    = pc_d_q;
  assign pc8_d   = pc8_d_q;
  assign valid_d = valid_d_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit; memory returns pc-tagged words.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic [31:0] ir_f;
  logic [31:0] pc_f;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;

  int n_vec;
  int n_err;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel), .imm16(imm16),
    .instr_index(instr_index), .jr_target(jr_target), .ir_f(ir_f),
    .pc_f(pc_f), .ir_d(ir_d), .pc_d(pc_d), .pc8_d(pc8_d), .valid_d(valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always_comb ir_f = mem_word(pc_f);

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  sel;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jr;
    logic [31:0] e_pc_f;
    logic [31:0] e_pc_d;   // IF/ID PC in delay-slot mode
    logic        e_valid;  // IF/ID valid in delay-slot mode
    logic        flush;    // redirect cycle: bubble when delay slots are off
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic [1:0] sel,
                              input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr,
                              input logic [31:0] epf, input logic [31:0] epd, input logic ev,
                              input logic fl);
    vec_t v;
    v.rst = rst; v.stl = stl; v.sel = sel; v.imm = imm; v.idx = idx; v.jr = jr;
    v.e_pc_f = epf; v.e_pc_d = epd; v.e_valid = ev; v.flush = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] epf, input logic [31:0] epd,
                       input logic ev, input logic fl);
    logic [31:0] e_ir, e_pd, e_p8;
    logic        e_v;
    e_v  = ev;
    e_pd = epd;
`ifndef FETCH_DELAY_SLOT_EN
    if (fl) begin
      e_v  = 1'b0;
      e_pd = 32'h0000_0000;
    end
`endif
    e_ir = e_v ? mem_word(e_pd) : 32'h0000_0000;
    e_p8 = e_v ? e_pd + 32'd8 : 32'h0000_0000;
    n_vec++;
    if (pc_f !== epf) begin
      n_err++; $display("FAIL %s pc_f: got %h want %h", name, pc_f, epf);
    end
    if (ir_d !== e_ir) begin
      n_err++; $display("FAIL %s ir_d: got %h want %h", name, ir_d, e_ir);
    end
    if (pc_d !== e_pd) begin
      n_err++; $display("FAIL %s pc_d: got %h want %h", name, pc_d, e_pd);
    end
    if (pc8_d !== e_p8) begin
      n_err++; $display("FAIL %s pc8_d: got %h want %h", name, pc8_d, e_p8);
    end
    if (valid_d !== e_v) begin
      n_err++; $display("FAIL %s valid_d: got %b want %b", name, valid_d, e_v);
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic [1:0] sel,
                      input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
    reset = rst; stall = stl; npc_sel = sel; imm16 = imm; instr_index = idx; jr_target = jr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; stall = 1'b0; npc_sel = 2'b00; imm16 = 16'h0000;
    instr_index = 26'h0; jr_target = 32'h0;

    vq.push_back(mk(1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 32'h0, 1'b0, 1'b0));
    // valid_d = 0: the branch request must be ignored
    vq.push_back(mk(1'b0, 1'b0, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3004, 32'h0000_3000, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3008, 32'h0000_3004, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_3008, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3004, 32'h0000_300C, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3008, 32'h0000_3004, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 32'h0000_3008, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3010, 32'h0000_300C, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3014, 32'h0000_3010, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b10, 16'h0000, 26'h0000C40, 32'h0, 32'h0000_3100, 32'h0000_3014, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3104, 32'h0000_3100, 1'b1, 1'b0));
    // stall beats redirect for two cycles, then jr is taken
    vq.push_back(mk(1'b0, 1'b1, 2'b11, 16'h0000, 26'h0, 32'h0000_3FFC, 32'h0000_3104, 32'h0000_3100, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 2'b11, 16'h0000, 26'h0, 32'h0000_3FFC, 32'h0000_3104, 32'h0000_3100, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b11, 16'h0000, 26'h0, 32'h0000_3FFC, 32'h0000_3FFC, 32'h0000_3104, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_4000, 32'h0000_3FFC, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b11, 16'h0000, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_4000, 1'b1, 1'b1));
    // sequential wrap; pc8_d of 0xFFFFFFFC wraps to 4
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b01, 16'h0001, 26'h0, 32'h0, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_0008, 32'h0000_0004, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b11, 16'h0000, 26'h0, 32'h9000_0000, 32'h9000_0000, 32'h0000_0008, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h9000_0004, 32'h9000_0000, 1'b1, 1'b0));
    // jump keeps the upper nibble of pc_d + 4
    vq.push_back(mk(1'b0, 1'b0, 2'b10, 16'h0000, 26'h3FFFFFF, 32'h0, 32'h9FFF_FFFC, 32'h9000_0004, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'hA000_0000, 32'h9FFF_FFFC, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3000, 32'h0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0, 32'h0000_3004, 32'h0000_3000, 1'b1, 1'b0));

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].stl, vq[i].sel, vq[i].imm, vq[i].idx, vq[i].jr);
      check($sformatf("vec%0d", i), vq[i].e_pc_f, vq[i].e_pc_d, vq[i].e_valid, vq[i].flush);
    end

    // stall held three cycles with a pending redirect, then resume sequentially
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 2'b11, 16'h0000, 26'h0, 32'h1234_5678);
      check($sformatf("stall%0d", k), 32'h0000_3004, 32'h0000_3000, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0);
    check("resume", 32'h0000_3008, 32'h0000_3004, 1'b1, 1'b0);

    // reset held two cycles, then first valid word at RESET_PC one cycle after release
    step(1'b1, 1'b0, 2'b11, 16'h0000, 26'h0, 32'h5555_0000);
    check("rst_a", 32'h0000_3000, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0);
    check("rst_b", 32'h0000_3000, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0);
    check("rst_rel", 32'h0000_3004, 32'h0000_3000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
